// File: rtl/dmem_responder.sv
// Multi-cycle data-memory responder for the MEM stage: stalls the pipeline for
// LATENCY cycles per access, returns registered load data and flags misaligned accesses.
module dmem_responder #(
   parameter int unsigned DEPTH     = 256,
   parameter int unsigned ADDR_BITS = 8,
   parameter int unsigned LATENCY   = 2
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [31:0] addr,
   input  logic [31:0] write_data,
   input  logic        mem_read,
   input  logic        mem_write,
   output logic [31:0] read_data,
   output logic        read_valid,
   output logic        mem_stall,
   output logic        misalign_err
);

   localparam int unsigned DATA_W       = 32;
   localparam int unsigned CNT_W        = 4;
   localparam bit          SINGLE_CYCLE = (LATENCY == 1);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      BUSY = 2'd1,
      DONE = 2'd2
   } state_t;

   logic [DATA_W-1:0]    mem [DEPTH];

   state_t               state;
   state_t               state_nxt;
   logic [CNT_W-1:0]     cnt;
   logic [CNT_W-1:0]     cnt_nxt;

   logic [ADDR_BITS-1:0] cap_idx;
   logic                 cap_mis;
   logic                 cap_rd;
   logic                 cap_wr;
   logic [DATA_W-1:0]    cap_wdata;

   logic                 req_c;
   logic                 stall_c;
   logic                 capture_c;
   logic                 access_c;

   logic [ADDR_BITS-1:0] acc_idx;
   logic                 acc_mis;
   logic                 acc_rd;
   logic                 acc_wr;
   logic [DATA_W-1:0]    acc_wdata;

   logic                 unused_addr_bits;

   assign req_c            = mem_read | mem_write;
   assign unused_addr_bits = ^addr[DATA_W-1:ADDR_BITS+2];
   assign mem_stall        = rst_n & stall_c;

   // Single-cycle accesses execute in IDLE straight from the inputs; otherwise from the capture
   assign acc_idx   = (state == IDLE) ? addr[ADDR_BITS+1:2]   : cap_idx;
   assign acc_mis   = (state == IDLE) ? (addr[1:0] != 2'b00)  : cap_mis;
   assign acc_rd    = (state == IDLE) ? mem_read              : cap_rd;
   assign acc_wr    = (state == IDLE) ? mem_write             : cap_wr;
   assign acc_wdata = (state == IDLE) ? write_data            : cap_wdata;

   // Next-state, stall and access strobes
   always_comb begin
      state_nxt = state;
      cnt_nxt   = cnt;
      stall_c   = 1'b0;
      capture_c = 1'b0;
      access_c  = 1'b0;
      case (state)
         IDLE: begin
            if (req_c) begin
               stall_c   = 1'b1;
               capture_c = 1'b1;
               if (SINGLE_CYCLE) begin
                  access_c  = 1'b1;
                  state_nxt = DONE;
               end else begin
                  cnt_nxt   = CNT_W'(LATENCY - 2);
                  state_nxt = BUSY;
               end
            end
         end
         BUSY: begin
            stall_c = 1'b1;
            if (cnt == '0) begin
               access_c  = 1'b1;
               state_nxt = DONE;
            end else begin
               cnt_nxt = cnt - CNT_W'(1);
            end
         end
         DONE:    state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
         cnt   <= '0;
      end else begin
         state <= state_nxt;
         cnt   <= cnt_nxt;
      end
   end

   // Request capture and registered completion outputs
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cap_idx      <= '0;
         cap_mis      <= 1'b0;
         cap_rd       <= 1'b0;
         cap_wr       <= 1'b0;
         cap_wdata    <= '0;
         read_data    <= '0;
         read_valid   <= 1'b0;
         misalign_err <= 1'b0;
      end else begin
         if (capture_c) begin
            cap_idx   <= addr[ADDR_BITS+1:2];
            cap_mis   <= (addr[1:0] != 2'b00);
            cap_rd    <= mem_read;
            cap_wr    <= mem_write;
            cap_wdata <= write_data;
         end
         read_valid   <= access_c & acc_rd;
         misalign_err <= access_c & acc_mis;
         if (access_c && acc_rd) begin
            read_data <= acc_mis ? '0 : mem[acc_idx];
         end
      end
   end

   // Array is not reset; writes are blocked while rst_n is low
   always_ff @(posedge clk) begin
      if (rst_n && access_c && acc_wr && !acc_mis) begin
         mem[acc_idx] <= acc_wdata;
      end
   end

endmodule

// File: tb/tb_dmem_responder.sv
// Scoreboard bench for dmem_responder: three instances with LATENCY 2, 1 and 4
// sharing one clock and reset, checked against a bench-side memory model.
module tb_dmem_responder;

   typedef struct packed {
      logic        ld;
      logic        mis;
      logic [31:0] data;
   } exp_t;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [31:0] addr         [3];
   logic [31:0] write_data   [3];
   logic [31:0] read_data    [3];
   logic        mem_read     [3];
   logic        mem_write    [3];
   logic        read_valid   [3];
   logic        mem_stall    [3];
   logic        misalign_err [3];

   logic [31:0] model   [3][256];
   logic [31:0] last_rd [3];
   int          done_cyc[3];
   exp_t        sb[$];
   int          checks = 0;
   int          errors = 0;
   int          cyc = 0;

   always #5 clk = ~clk;
   always @(posedge clk) cyc++;

   dmem_responder #(.DEPTH(256), .ADDR_BITS(8), .LATENCY(2)) u_lat2 (
      .clk(clk), .rst_n(rst_n), .addr(addr[0]), .write_data(write_data[0]),
      .mem_read(mem_read[0]), .mem_write(mem_write[0]), .read_data(read_data[0]),
      .read_valid(read_valid[0]), .mem_stall(mem_stall[0]), .misalign_err(misalign_err[0]));

   dmem_responder #(.DEPTH(256), .ADDR_BITS(8), .LATENCY(1)) u_lat1 (
      .clk(clk), .rst_n(rst_n), .addr(addr[1]), .write_data(write_data[1]),
      .mem_read(mem_read[1]), .mem_write(mem_write[1]), .read_data(read_data[1]),
      .read_valid(read_valid[1]), .mem_stall(mem_stall[1]), .misalign_err(misalign_err[1]));

   dmem_responder #(.DEPTH(256), .ADDR_BITS(8), .LATENCY(4)) u_lat4 (
      .clk(clk), .rst_n(rst_n), .addr(addr[2]), .write_data(write_data[2]),
      .mem_read(mem_read[2]), .mem_write(mem_write[2]), .read_data(read_data[2]),
      .read_valid(read_valid[2]), .mem_stall(mem_stall[2]), .misalign_err(misalign_err[2]));

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
      end
   endtask

   // Drive a request and push its expected completion from the model
   task automatic issue(input int d, input logic rd, input logic wr,
                        input logic [31:0] a, input logic [31:0] wd);
      exp_t       e;
      logic [7:0] idx;
      logic       mis;
      idx    = a[9:2];
      mis    = (a[1:0] != 2'b00);
      e.ld   = rd;
      e.mis  = mis;
      e.data = (rd && !mis) ? model[d][idx] : 32'h0;
      if (wr && !mis) model[d][idx] = wd;
      sb.push_back(e);
      addr[d]       = a;
      write_data[d] = wd;
      mem_read[d]   = rd;
      mem_write[d]  = wr;
      #1;
   endtask

   // Count stall cycles up to DONE, compare against the scoreboard, then release the request
   task automatic complete(input int d, input int lat);
      int   stalls;
      bit   done;
      exp_t e;
      stalls = 0;
      done   = 1'b0;
      for (int i = 0; i < 20 && !done; i++) begin
         if (mem_stall[d]) begin
            stalls++;
            @(negedge clk);
            #1;
         end else begin
            done = 1'b1;
         end
      end
      check("done_timeout", 32'(done), 32'd1);
      check("stall_cycles", 32'(stalls), 32'(lat));
      if (sb.size() == 0) begin
         check("sb_underflow", 32'd1, 32'd0);
      end else begin
         e = sb.pop_front();
         check("read_valid", 32'(read_valid[d]), 32'(e.ld));
         check("misalign_err", 32'(misalign_err[d]), 32'(e.mis));
         if (e.ld) begin
            check("read_data", read_data[d], e.data);
            last_rd[d] = e.data;
         end else begin
            check("read_data_hold", read_data[d], last_rd[d]);
         end
      end
      done_cyc[d]  = cyc;
      mem_read[d]  = 1'b0;
      mem_write[d] = 1'b0;
      @(negedge clk);
      #1;
      check("pulse_clear", 32'({read_valid[d], misalign_err[d]}), 32'd0);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      int t0;
      rst_n = 1'b0;
      for (int d = 0; d < 3; d++) begin
         addr[d]       = 32'h0;
         write_data[d] = 32'h0;
         mem_read[d]   = 1'b0;
         mem_write[d]  = 1'b0;
         last_rd[d]    = 32'h0;
      end
      mem_read[0] = 1'b1;
      repeat (3) @(negedge clk);
      #1;
      check("rst_stall_gated", 32'(mem_stall[0]), 32'd0);
      for (int d = 0; d < 3; d++) begin
         check("rst_read_data", read_data[d], 32'h0);
         check("rst_pulses", 32'({read_valid[d], misalign_err[d]}), 32'd0);
      end
      mem_read[0] = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      #1;
      repeat (2) begin
         check("idle_quiet", 32'({read_valid[0], misalign_err[0], mem_stall[0]}), 32'd0);
         @(negedge clk);
         #1;
      end

      // LATENCY=2: store/load, wrap-around, misalignment, simultaneous read+write
      issue(0, 1'b0, 1'b1, 32'h10, 32'hDEADBEEF); complete(0, 2);
      issue(0, 1'b1, 1'b0, 32'h10, 32'h0);        complete(0, 2);
      issue(0, 1'b0, 1'b1, 32'h400, 32'h55);      complete(0, 2);
      issue(0, 1'b1, 1'b0, 32'h0, 32'h0);         complete(0, 2);
      issue(0, 1'b0, 1'b1, 32'h13, 32'h12345678); complete(0, 2);
      issue(0, 1'b1, 1'b0, 32'h10, 32'h0);        complete(0, 2);
      issue(0, 1'b1, 1'b0, 32'h12, 32'h0);        complete(0, 2);
      issue(0, 1'b0, 1'b1, 32'h20, 32'hA);        complete(0, 2);
      issue(0, 1'b1, 1'b1, 32'h20, 32'hB);        complete(0, 2);
      issue(0, 1'b1, 1'b0, 32'h20, 32'h0);        complete(0, 2);

      // LATENCY=1: preload then back-to-back loads
      issue(1, 1'b0, 1'b1, 32'h0, 32'h11); complete(1, 1);
      issue(1, 1'b0, 1'b1, 32'h4, 32'h22); complete(1, 1);
      issue(1, 1'b1, 1'b0, 32'h0, 32'h0);  complete(1, 1);
      t0 = done_cyc[1];
      issue(1, 1'b1, 1'b0, 32'h4, 32'h0);  complete(1, 1);
      check("b2b_spacing", 32'(done_cyc[1] - t0), 32'd2);

      // LATENCY=4: old contents, then a store aborted by reset
      issue(2, 1'b0, 1'b1, 32'h8, 32'h77); complete(2, 4);
      addr[2]       = 32'h8;
      write_data[2] = 32'h99;
      mem_write[2]  = 1'b1;
      @(posedge clk); #1;
      @(posedge clk); #1;
      check("busy_stall", 32'(mem_stall[2]), 32'd1);
      rst_n = 1'b0;
      #1;
      check("abort_stall", 32'(mem_stall[2]), 32'd0);
      check("abort_pulses", 32'({read_valid[2], misalign_err[2]}), 32'd0);
      check("abort_read_data", read_data[2], 32'h0);
      for (int d = 0; d < 3; d++) last_rd[d] = 32'h0;
      mem_write[2] = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      #1;
      issue(2, 1'b1, 1'b0, 32'h8, 32'h0); complete(2, 4);

      // Reset mid-access with the request held: re-accepted as new after release
      addr[2]       = 32'h8;
      write_data[2] = 32'h99;
      mem_write[2]  = 1'b1;
      @(posedge clk); #1;
      @(posedge clk); #1;
      rst_n = 1'b0;
      #1;
      check("held_rst_stall", 32'(mem_stall[2]), 32'd0);
      for (int d = 0; d < 3; d++) last_rd[d] = 32'h0;
      @(negedge clk);
      rst_n = 1'b1;
      issue(2, 1'b0, 1'b1, 32'h8, 32'h99); complete(2, 4);
      issue(2, 1'b1, 1'b0, 32'h8, 32'h0);  complete(2, 4);

      check("sb_drained", 32'(sb.size()), 32'd0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
